vector_checker: RTL and testbench
=================================

# vector_checker

Synthesizable stimulus-player / response-checker for 16-bit sequential chips (Register, PC, RAM-style parts). It fetches 48-bit test vectors from a synchronous ROM, drives `in`/`load` into the device under test (DUT), compares the DUT's `out` against each vector's expected field, and reports the mismatch count and the first failing index. It sits beside a DUT on an FPGA or in a self-checking top-level, replacing file-based vector playback.

## Interface
- `DEPTH`, 148: maximum number of vectors in the ROM.
- `AW`, 8: ROM address width; must satisfy 2^AW ≥ DEPTH.
- `CHECK_LAT`, 1: cycles from a vector appearing on `dut_in`/`dut_load` to the cycle in which `dut_out` is compared; range 1–4.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle request to begin a run; honoured only in IDLE or DONE.
- `rom_addr`  out  AW: vector address.
- `rom_data`  in  48: vector at the address presented on the previous cycle. Fields: [47:32] in, [31] end marker, [16] load, [15:0] expected out. Bits [30:17] are ignored.
- `dut_in`  out  16: stimulus data, registered.
- `dut_load`  out  1: stimulus load, registered; 0 whenever no vector is applied.
- `dut_out`  in  16: DUT response.
- `busy`  out  1: a run is in progress.
- `done`  out  1: level; the run is complete. Held until the next `start` or reset.
- `pass`  out  1: `done` and `err_count == 0`.
- `err_count`  out  16: number of mismatches; saturates at 16'hFFFF.
- `vec_count`  out  AW+1: number of vectors applied.
- `first_err_idx`  out  AW: index of the first mismatching vector.
- `first_err_vld`  out  1: `first_err_idx` is valid.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + `start`:
  - Clear `err_count`, `vec_count`, `first_err_vld` and `done`.
  - Set `rom_addr` to 0 and go to RUN.
- RUN: issue one ROM address per cycle. The returned vector k is then handled as follows:
  - If `rom_data[31]=1`, the vector is a terminator. It is not applied, and the state goes to DRAIN.
  - Otherwise `dut_in` takes `rom_data[47:32]`, `dut_load` takes `rom_data[16]`, and `vec_count` increments.
  - The expected field and index k enter a CHECK_LAT-deep valid-tagged delay line.
  - After vector DEPTH-1 is applied, go to DRAIN. Addresses past DEPTH-1 are never issued.
- DRAIN: `dut_load` is 0. Stay until the delay line holds no valid entries, then go to DONE.
- Compare: a valid delay-line entry whose expected field differs from `dut_out` causes:
  - `err_count` increments, saturating.
  - If `first_err_vld` is 0, `first_err_idx` takes the entry's index and `first_err_vld` is set to 1.
- Comparison uses all 16 bits, with no don't-care masking. Bubble entries are never compared.
- `busy` is 1 in RUN and DRAIN. `done` is 1 only in DONE.
- `start` during RUN or DRAIN is ignored.
- Reset values: state IDLE; all outputs 0, including `rom_addr`, `dut_in`, `dut_load`, `pass` and the counters. The delay line is cleared.
- Reset mid-run: immediate return to IDLE with all of the above values. No partial result survives.

## Timing
- Cycle 0: `start` sampled. Cycle 1: `rom_addr`=0. Cycle 2: `rom_data` = vector 0. Cycle 3: vector 0 on `dut_in`/`dut_load`.
- Vector k is compared against `dut_out` in cycle 3+k+CHECK_LAT.
- Throughput: one vector per cycle, with no stalls.
- For a run of N applied vectors and no terminator:
  - Last comparison in cycle 3+(N-1)+CHECK_LAT.
  - `done` rises in the following cycle.
- A terminator at index k leads to the same end timing as a run with N=k.
- A terminator at index 0 means zero vectors are applied. `done` rises within CHECK_LAT+3 cycles of `start`, with `pass`=1 and `vec_count`=0.
- `err_count` and `first_err_*` update in the cycle after the failing comparison.

## Test plan
- Register DUT, CHECK_LAT=1, 4 vectors, then a terminator:
  - Stimulus (in, load, exp): (5,1,0), (−1,1,5), (7,0,−1), (0,0,−1).
  - Required: `done`, `pass`=1, `vec_count`=4, `err_count`=0. `dut_load` pattern 1,1,0,0.
- Same vectors with vector 2's expected value changed to 9:
  - `err_count`=1, `first_err_idx`=2, `first_err_vld`=1, `pass`=0.
- DUT tied to constant 0, DEPTH=148, no terminator:
  - 148 vectors applied, no address above 147 issued.
  - `err_count` equals the number of nonzero expected fields.
  - `done` at cycle 3+147+1+1 after `start`.
- Terminator at address 0:
  - `dut_load` stays 0, `vec_count`=0, `pass`=1.
- Pulse `rst_n` low in cycle 20 of a run:
  - All outputs return to 0 asynchronously and the state is IDLE.
  - A new `start` reruns and gives the same result as an uninterrupted run.
- `start` pulsed during RUN: no effect on counters or addresses. `start` after DONE clears the results and reruns.

Source files
------------

// File: rtl/vector_checker_if.sv
// Stimulus/response bus between vector_checker, its vector ROM and the chip under test.
// The checker takes the master side; the ROM and the tested chip sit on the slave side.
interface vector_checker_if #(
  parameter int AW = 8
);
  logic [AW-1:0] rom_addr;
  logic [47:0]   rom_data;
  logic [15:0]   dut_in;
  logic          dut_load;
  logic [15:0]   dut_out;

  modport master (
    output rom_addr, dut_in, dut_load,
    input  rom_data, dut_out
  );

  modport slave (
    input  rom_addr, dut_in, dut_load,
    output rom_data, dut_out
  );
endinterface

// File: rtl/vector_checker.sv
// Plays 48-bit vectors from a synchronous ROM into a 16-bit sequential chip and checks
// its response CHECK_LAT cycles later, counting mismatches and keeping the first failing index.
module vector_checker #(
  parameter int DEPTH     = 148,
  parameter int AW        = 8,
  parameter int CHECK_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  vector_checker_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [AW:0]      vec_count,
  output logic [AW-1:0]    first_err_idx,
  output logic             first_err_vld
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef struct packed {
    logic          vld;
    logic [15:0]   exp;
    logic [AW-1:0] idx;
  } entry_t;

  logic [1:0]    state;
  logic          issuing;     // an address is being presented to the ROM this cycle
  logic          fetch_vld;   // rom_data holds the vector addressed last cycle
  logic [AW-1:0] fetch_idx;
  entry_t        dline [CHECK_LAT+1];

  logic   term;
  logic   apply;
  logic   clear;
  logic   line_busy;
  logic   miss;
  entry_t push;
  logic   unused_rsvd;

  assign unused_rsvd = ^bus.rom_data[30:17];

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == 16'h0000);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    term      = bus.rom_data[31];
    apply     = (state == S_RUN) && fetch_vld && !term;
    clear     = ((state == S_IDLE) || (state == S_DONE)) && start;
    push.vld  = apply;
    push.exp  = bus.rom_data[15:0];
    push.idx  = fetch_idx;
    line_busy = 1'b0;
    // Stage CHECK_LAT is being compared now; only earlier stages keep the run alive.
    for (int i = 0; i < CHECK_LAT; i++) line_busy = line_busy | dline[i].vld;
    miss = dline[CHECK_LAT].vld && (dline[CHECK_LAT].exp != bus.dut_out);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      issuing      <= 1'b0;
      fetch_vld    <= 1'b0;
      fetch_idx    <= '0;
      bus.rom_addr <= '0;
      bus.dut_in   <= '0;
      bus.dut_load <= 1'b0;
      vec_count    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          bus.dut_load <= 1'b0;
          if (start) begin
            state        <= S_RUN;
            bus.rom_addr <= '0;
            issuing      <= 1'b1;
            fetch_vld    <= 1'b0;
            vec_count    <= '0;
          end
        end
        S_RUN: begin
          fetch_vld <= issuing;
          fetch_idx <= bus.rom_addr;
          if (issuing) begin
            if (bus.rom_addr == LAST_ADDR) issuing <= 1'b0;
            else                           bus.rom_addr <= bus.rom_addr + 1'b1;
          end
          bus.dut_load <= 1'b0;
          if (fetch_vld && term) begin
            state     <= S_DRAIN;
            issuing   <= 1'b0;
            fetch_vld <= 1'b0;
          end else if (apply) begin
            bus.dut_in   <= bus.rom_data[47:32];
            bus.dut_load <= bus.rom_data[16];
            vec_count    <= vec_count + 1'b1;
            if (fetch_idx == LAST_ADDR) state <= S_DRAIN;
          end
        end
        default: begin
          bus.dut_load <= 1'b0;
          issuing      <= 1'b0;
          fetch_vld    <= 1'b0;
          if (!line_busy) state <= S_DONE;
        end
      endcase
    end
  end

  // NOTE: the delay line is reset so that no stale valid tag can be compared after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= CHECK_LAT; i++) dline[i] <= '0;
    end else begin
      dline[0] <= push;
      for (int i = 1; i <= CHECK_LAT; i++) dline[i] <= dline[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else if (clear) begin
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else if (miss) begin
      if (err_count != 16'hFFFF) err_count <= err_count + 1'b1;
      if (!first_err_vld) begin
        first_err_idx <= dline[CHECK_LAT].idx;
        first_err_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vector_checker.sv
// Bench for vector_checker: a behavioural ROM and tested chip, a scoreboard of applied
// vectors checked cycle by cycle, and end-of-run result checks.
module tb_vector_checker;
  localparam int DEPTH = 148;
  localparam int AW    = 8;
  localparam int LAT   = 1;

  typedef struct {
    logic [15:0] din;
    logic        load;
    logic [15:0] exp;
    logic        term;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic busy, done, pass, first_err_vld;
  logic [15:0]   err_count;
  logic [AW:0]   vec_count;
  logic [AW-1:0] first_err_idx;

  int n_vec  = 0;
  int n_miss = 0;

  vec_t prog [256];
  vec_t t1 [5];

  always #5 clk = ~clk;

  vector_checker_if #(.AW(AW)) bus ();

  vector_checker #(.DEPTH(DEPTH), .AW(AW), .CHECK_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .vec_count(vec_count), .first_err_idx(first_err_idx), .first_err_vld(first_err_vld)
  );

  // Synchronous ROM; reserved bits carry junk that must be ignored.
  always @(posedge clk) begin
    vec_t v;
    v = prog[bus.rom_addr];
    bus.rom_data <= {v.din, v.term, 14'h2AAA, v.load, v.exp};
  end

  // Tested chip: a register seen through one retiming flop, so each vector is compared
  // against the value held before its own load; alternatively tied to constant 0.
  logic [15:0] reg_q, reg_view;
  logic model_clr = 1'b0;
  bit   const_zero = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= 16'h0; reg_view <= 16'h0;
    end else if (model_clr) begin
      reg_q <= 16'h0; reg_view <= 16'h0;
    end else begin
      if (bus.dut_load) reg_q <= bus.dut_in;
      reg_view <= reg_q;
    end
  end
  assign bus.dut_out = const_zero ? 16'h0 : reg_view;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic fill_junk();
    for (int i = 0; i < 256; i++)
      prog[i] = '{din: 16'(i * 13 + 3), load: 1'b1, exp: 16'hA5A5, term: 1'b0};
  endtask

  task automatic load_t1();
    fill_junk();
    for (int i = 0; i < 5; i++) prog[i] = t1[i];
  endtask

  task automatic load_full(output int nz, output int first_nz);
    nz = 0; first_nz = -1;
    fill_junk();
    for (int i = 0; i < DEPTH; i++) begin
      prog[i] = '{din: 16'($urandom_range(1, 16'hFFFF)), load: 1'($urandom_range(0, 1)),
                  exp: (i % 4 == 0) ? 16'h0 : 16'(i * 37 + 1), term: 1'b0};
      if (prog[i].exp != 16'h0) begin
        nz++;
        if (first_nz < 0) first_nz = i;
      end
    end
  endtask

  // One run: scoreboard of vectors expected on dut_in/dut_load from cycle 3 onward.
  task automatic run(input string nm, input int exp_err, input int exp_fidx,
                     input bit exp_fvld, input int extra_start_at);
    vec_t q[$];
    vec_t v;
    int   n_app, k, done_at;
    bit   load_ok, addr_ok;
    for (int i = 0; i < DEPTH && !prog[i].term; i++) q.push_back(prog[i]);
    n_app = q.size();
    k = 0; done_at = -1; load_ok = 1'b1; addr_ok = 1'b1;
    @(negedge clk); model_clr = 1'b1;
    @(negedge clk); model_clr = 1'b0;
    start = 1'b1;
    @(posedge clk);
    for (int m = 1; m < 400 && done_at < 0; m++) begin
      @(negedge clk);
      start = (m == extra_start_at);
      if (m == 1) check({nm, " busy"}, 32'(busy), 32'd1);
      if (bus.rom_addr > AW'(DEPTH - 1)) addr_ok = 1'b0;
      if (m >= 3 && q.size() > 0) begin
        v = q.pop_front();
        check($sformatf("%s v%0d din", nm, k), 32'(bus.dut_in), 32'(v.din));
        check($sformatf("%s v%0d load", nm, k), 32'(bus.dut_load), 32'(v.load));
        k++;
      end else if (bus.dut_load) begin
        load_ok = 1'b0;
      end
      if (done) done_at = m;
    end
    start = 1'b0;
    check({nm, " done_cycle"}, 32'(done_at), 32'(3 + n_app + LAT));
    check({nm, " vec_count"}, 32'(vec_count), 32'(n_app));
    check({nm, " err_count"}, 32'(err_count), 32'(exp_err));
    check({nm, " pass"}, 32'(pass), 32'(exp_err == 0));
    check({nm, " first_err_vld"}, 32'(first_err_vld), 32'(exp_fvld));
    if (exp_fvld) check({nm, " first_err_idx"}, 32'(first_err_idx), 32'(exp_fidx));
    check({nm, " idle_load_zero"}, 32'(load_ok), 32'd1);
    check({nm, " addr_in_range"}, 32'(addr_ok), 32'd1);
    @(negedge clk);
    check({nm, " done_held"}, 32'({done, busy}), 32'b10);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " rom_addr"}, 32'(bus.rom_addr), 32'd0);
    check({nm, " dut_in"}, 32'(bus.dut_in), 32'd0);
    check({nm, " dut_load"}, 32'(bus.dut_load), 32'd0);
    check({nm, " status"}, 32'({busy, done, pass, first_err_vld}), 32'd0);
    check({nm, " err_count"}, 32'(err_count), 32'd0);
    check({nm, " vec_count"}, 32'(vec_count), 32'd0);
    check({nm, " first_err_idx"}, 32'(first_err_idx), 32'd0);
  endtask

  initial begin
    int nz, first_nz;
    t1[0] = '{din: 16'd5,     load: 1'b1, exp: 16'd0,     term: 1'b0};
    t1[1] = '{din: 16'hFFFF,  load: 1'b1, exp: 16'd5,     term: 1'b0};
    t1[2] = '{din: 16'd7,     load: 1'b0, exp: 16'hFFFF,  term: 1'b0};
    t1[3] = '{din: 16'd0,     load: 1'b0, exp: 16'hFFFF,  term: 1'b0};
    t1[4] = '{din: 16'h1234,  load: 1'b1, exp: 16'h4321,  term: 1'b1};
    fill_junk();

    #1 rst_n = 1'b0;
    #20 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    load_t1();
    run("reg_ok", 0, 0, 1'b0, 0);

    load_t1();
    prog[2].exp = 16'd9;
    run("reg_err", 1, 2, 1'b1, 0);

    load_t1();
    run("rerun_after_done", 0, 0, 1'b0, 0);

    run("start_in_run", 0, 0, 1'b0, 4);

    load_t1();
    prog[0].term = 1'b1;
    run("term_at_0", 0, 0, 1'b0, 0);

    const_zero = 1'b1;
    load_full(nz, first_nz);
    run("full_depth", nz, first_nz, 1'b1, 0);

    @(negedge clk) start = 1'b1;
    @(posedge clk) start = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_run_reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_idle", 32'({busy, done}), 32'd0);
    run("full_after_reset", nz, first_nz, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
